// File: rtl/spi_mosi_tx.sv
// SPI mode-0 master transmit engine: serializes one word MSB-first onto mosi
// with matching spi_clk and active-low chip select, all outputs registered.
module spi_mosi_tx #(
  parameter int W_DATA  = 32,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W_DATA-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_done,
  output logic              busy,
  output logic              spi_clk,
  output logic              spi_cs_n,
  output logic              mosi
);

  localparam int BW = $clog2(W_DATA);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(W_DATA - 1);

  // Handshake: a word is taken on any rising edge where tx_valid && tx_ready;
  // tx_ready is high exactly while idle, and tx_valid is ignored otherwise.
  typedef enum logic [2:0] {IDLE, LEAD, HIGH, LOW, TRAIL} state_t;

  state_t            state;
  logic [W_DATA-1:0] shreg;
  logic [BW-1:0]     bit_cnt;
  logic [DW-1:0]     div_cnt;
  logic              phase_end;

  assign phase_end = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      div_cnt  <= '0;
      tx_ready <= 1'b1;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
      spi_clk  <= 1'b0;
      spi_cs_n <= 1'b1;
      mosi     <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (state != IDLE) begin
        div_cnt <= phase_end ? '0 : div_cnt + 1'b1;
      end
      case (state)
        IDLE: begin
          if (tx_valid) begin
            state    <= LEAD;
            shreg    <= tx_data;
            bit_cnt  <= '0;
            div_cnt  <= '0;
            tx_ready <= 1'b0;
            busy     <= 1'b1;
            spi_cs_n <= 1'b0;
            spi_clk  <= 1'b0;
            mosi     <= tx_data[W_DATA-1];
          end
        end
        LEAD: begin
          if (phase_end) begin
            state   <= HIGH;
            spi_clk <= 1'b1;
          end
        end
        HIGH: begin
          if (phase_end) begin
            spi_clk <= 1'b0;
            if (bit_cnt != BIT_LAST) begin
              // Next bit changes on the falling edge, mid-way between rises.
              state   <= LOW;
              shreg   <= shreg << 1;
              mosi    <= shreg[W_DATA-2];
              bit_cnt <= bit_cnt + 1'b1;
            end else begin
              state <= TRAIL;
            end
          end
        end
        LOW: begin
          if (phase_end) begin
            state   <= HIGH;
            spi_clk <= 1'b1;
          end
        end
        TRAIL: begin
          if (phase_end) begin
            state    <= IDLE;
            spi_cs_n <= 1'b1;
            mosi     <= 1'b0;
            tx_done  <= 1'b1;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_mosi_tx.sv
// Bench for spi_mosi_tx: a mode-0 slave model checks each frame against an
// expected-word queue; a second 8-bit, CLK_DIV=1 instance covers the corner.
module tb_spi_mosi_tx;

  localparam int W = 32;
  localparam int D = 4;
  localparam int LOW_EXP = D * (2 * W + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [W-1:0] tx_data_a = '0;
  logic tx_valid_a = 1'b0;
  logic tx_ready_a, tx_done_a, busy_a, spi_clk_a, spi_cs_n_a, mosi_a;

  logic [7:0] tx_data_b = '0;
  logic tx_valid_b = 1'b0;
  logic tx_ready_b, tx_done_b, busy_b, spi_clk_b, spi_cs_n_b, mosi_b;

  spi_mosi_tx #(.W_DATA(W), .CLK_DIV(D)) dut_a (
    .clk(clk), .rst(rst), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
    .tx_ready(tx_ready_a), .tx_done(tx_done_a), .busy(busy_a),
    .spi_clk(spi_clk_a), .spi_cs_n(spi_cs_n_a), .mosi(mosi_a)
  );

  spi_mosi_tx #(.W_DATA(8), .CLK_DIV(1)) dut_b (
    .clk(clk), .rst(rst), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
    .tx_ready(tx_ready_b), .tx_done(tx_done_b), .busy(busy_b),
    .spi_clk(spi_clk_b), .spi_cs_n(spi_cs_n_b), .mosi(mosi_b)
  );

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Slave model and frame checker for dut_a, sampled on the falling clk edge.
  int low_cnt = 0, rise_cnt = 0, high_cnt = 1000, last_gap = 0;
  int frames_started = 0, done_cnt = 0;
  logic [W-1:0] rx = '0;
  logic prev_cs = 1'b1, prev_clk = 1'b0, prev_mosi = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      low_cnt = 0; rise_cnt = 0; rx = '0;
      prev_cs = 1'b1; prev_clk = 1'b0; prev_mosi = 1'b0;
    end else begin
      if (busy_a == tx_ready_a) chk("busy_vs_ready", {busy_a, tx_ready_a}, {~tx_ready_a, tx_ready_a});
      if (!spi_cs_n_a) begin
        if (prev_cs) begin
          frames_started++;
          last_gap = high_cnt;
          low_cnt = 0; rise_cnt = 0; rx = '0;
        end else if (mosi_a != prev_mosi) begin
          chk("mosi_changes_on_sclk_fall", {30'd0, prev_clk, spi_clk_a}, 32'd2);
        end
        low_cnt++;
        if (spi_clk_a && !prev_clk) begin
          rx = {rx[W-2:0], mosi_a};
          rise_cnt++;
        end
        high_cnt = 0;
      end else begin
        if (!prev_cs) begin
          chk("done_on_cs_rise", {31'd0, tx_done_a}, 32'd1);
          chk("cs_low_cycles", low_cnt, LOW_EXP);
          chk("sclk_rises", rise_cnt, W);
          if (exp_q.size() == 0) chk("unexpected_frame", rx, 32'hxxxx_xxxx);
          else chk("rx_word", rx, exp_q.pop_front());
        end
        high_cnt++;
      end
      if (tx_done_a) done_cnt++;
      prev_cs = spi_cs_n_a; prev_clk = spi_clk_a; prev_mosi = mosi_a;
    end
  end

  task automatic send(input logic [W-1:0] d, input logic [W-1:0] e);
    int n;
    n = 0;
    @(negedge clk);
    while (!tx_ready_a && n < 2000) begin @(negedge clk); n++; end
    chk("send_ready_timeout", {31'd0, tx_ready_a}, 32'd1);
    tx_data_a = d;
    tx_valid_a = 1'b1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    tx_valid_a = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 2000) begin @(negedge clk); n++; end
    chk("wait_done_timeout", done_cnt, target);
  endtask

  typedef struct {
    logic [W-1:0] data;
    logic [W-1:0] exp_word;
  } vec_t;
  vec_t vec[6];

  initial begin
    int d0, f0;
    logic [W-1:0] r;

    vec[0] = '{32'hA5A5_0F0F, 32'hA5A5_0F0F};
    vec[1] = '{32'h8000_0001, 32'h8000_0001};
    vec[2] = '{32'h0000_0000, 32'h0000_0000};
    vec[3] = '{32'h5555_AAAA, 32'h5555_AAAA};
    for (int i = 4; i < 6; i++) begin
      r = $urandom;
      vec[i] = '{r, r};
    end

    // Reset with tx_valid asserted: nothing may start.
    tx_valid_a = 1'b1; tx_data_a = 32'hFFFF_FFFF;
    tx_valid_b = 1'b1; tx_data_b = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_ready", {31'd0, tx_ready_a}, 32'd1);
      chk("rst_busy", {31'd0, busy_a}, 32'd0);
      chk("rst_cs_n", {31'd0, spi_cs_n_a}, 32'd1);
      chk("rst_sclk", {31'd0, spi_clk_a}, 32'd0);
      chk("rst_mosi", {31'd0, mosi_a}, 32'd0);
      chk("rst_done", {31'd0, tx_done_a}, 32'd0);
    end
    tx_valid_a = 1'b0; tx_valid_b = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_no_frame", frames_started, 0);

    for (int i = 0; i < 6; i++) begin
      d0 = done_cnt;
      send(vec[i].data, vec[i].exp_word);
      wait_done(d0 + 1);
      repeat (2) @(negedge clk);
      chk("single_done_pulse", done_cnt, d0 + 1);
    end

    // Busy rejection: second request mid-frame is dropped.
    d0 = done_cnt; f0 = frames_started;
    send(32'hDEAD_BEEF, 32'hDEAD_BEEF);
    repeat (49) @(negedge clk);
    tx_data_a = 32'h1234_5678; tx_valid_a = 1'b1;
    @(posedge clk); #1;
    tx_valid_a = 1'b0;
    wait_done(d0 + 1);
    repeat (300) @(negedge clk);
    chk("reject_frames", frames_started, f0 + 1);
    chk("reject_done", done_cnt, d0 + 1);
    chk("reject_queue_empty", exp_q.size(), 0);

    // Back-to-back with tx_valid held high.
    d0 = done_cnt;
    send(32'h0000_0001, 32'h0000_0001);
    tx_valid_a = 1'b1;
    tx_data_a = 32'hFFFF_FFFF;
    exp_q.push_back(32'hFFFF_FFFF);
    for (int n = 0; n < 2000 && !tx_done_a; n++) @(negedge clk);
    @(posedge clk); #1;
    tx_valid_a = 1'b0;
    wait_done(d0 + 2);
    chk("b2b_gap", last_gap, 1);
    repeat (2) @(negedge clk);
    chk("b2b_done_count", done_cnt, d0 + 2);

    // Reset mid-frame.
    d0 = done_cnt;
    send(32'h1357_2468, 32'h1357_2468);
    repeat (99) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_cs_n", {31'd0, spi_cs_n_a}, 32'd1);
    chk("midrst_sclk", {31'd0, spi_clk_a}, 32'd0);
    chk("midrst_mosi", {31'd0, mosi_a}, 32'd0);
    chk("midrst_ready", {31'd0, tx_ready_a}, 32'd1);
    void'(exp_q.pop_back());
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_no_done", done_cnt, d0);
    send(32'h0000_CAFE, 32'h0000_CAFE);
    wait_done(d0 + 1);

    // W_DATA=8, CLK_DIV=1 corner on dut_b.
    begin
      int idx, rises, toggles, ended;
      logic [16:0] pat;
      logic [7:0] rxb;
      logic pclk;
      idx = 0; rises = 0; toggles = 0; ended = 0; pat = '0; rxb = '0; pclk = 1'b0;
      @(negedge clk);
      tx_data_b = 8'h81; tx_valid_b = 1'b1;
      @(posedge clk); #1;
      tx_valid_b = 1'b0;
      for (int n = 0; n < 40 && ended == 0; n++) begin
        @(negedge clk);
        if (!spi_cs_n_b) begin
          if (idx < 17) pat[idx] = spi_clk_b;
          idx++;
          if (spi_clk_b && !pclk) begin rxb = {rxb[6:0], mosi_b}; rises++; end
          if (spi_clk_b != pclk) toggles++;
        end else if (idx > 0) begin
          chk("b_done_on_cs_rise", {31'd0, tx_done_b}, 32'd1);
          ended = 1;
        end
        pclk = spi_clk_b;
      end
      chk("b_frame_ended", ended, 1);
      chk("b_cs_low_cycles", idx, 17);
      chk("b_rx_word", {24'd0, rxb}, 32'h81);
      chk("b_rises", rises, 8);
      chk("b_toggles", toggles, 16);
      chk("b_sclk_pattern", {15'd0, pat}, 32'h0AAAA);
    end

    repeat (5) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/spi_mosi_tx.md
Name: spi_mosi_tx

Overview:
SPI master transmit engine: serializes one CPU word onto MOSI and generates the matching spi_clk and active-low chip select. It is the outbound counterpart of the MISO receiver behind the SPI register file. The regfile hands it the word written to the MOSI register through a valid/ready handshake. SPI mode 0 (CPOL=0, CPHA=0), MSB first.

Parameters:
W_DATA, 32, bits per frame (≥2)
CLK_DIV, 4, clk cycles per spi_clk half-period (≥1)

Ports:
clk  input  1  system clock
rst  input  1  reset
tx_data  input  W_DATA  word to send; sampled only on accept
tx_valid  input  1  request to send tx_data
tx_ready  output  1  engine idle, can accept
tx_done  output  1  one-cycle pulse at frame completion
busy  output  1  frame in progress (inverse of tx_ready)
spi_clk  output  1  serial clock
spi_cs_n  output  1  chip select, active low
mosi  output  1  serial data out

Behaviour:
- Reset: rst, asynchronous, active-high; clock clk. All state elements rising-edge clk.
- Reset values: state=IDLE, tx_ready=1, busy=0, tx_done=0, spi_clk=0, spi_cs_n=1, mosi=0, shift register=0, counters=0.
- All outputs are registered. tx_ready is high iff state==IDLE.
- Accept: on an edge where tx_valid&&tx_ready, latch tx_data into shift register and enter LEAD. Later changes to tx_data have no effect. tx_valid is ignored while busy; nothing is queued.
- The divider counter counts 0..CLK_DIV-1. Each of LEAD, HIGH, LOW and TRAIL lasts exactly CLK_DIV cycles.
- IDLE: cs_n=1, spi_clk=0, mosi=0.
- LEAD: cs_n=0, spi_clk=0, mosi=tx_data[W_DATA-1]. Exit to HIGH.
- HIGH: spi_clk=1; the slave samples on the rising edge. mosi holds.
  - If bit counter < W_DATA-1, go to LOW.
  - Otherwise go to TRAIL.
- LOW: spi_clk=0. On entry, shift left and present the next bit on mosi, then increment the bit counter. Exit to HIGH.
- TRAIL: spi_clk=0, cs_n=0, mosi holds the LSB. On exit: cs_n=1, mosi=0, tx_done=1 for exactly one cycle, state=IDLE, tx_ready=1.
- Frame timing: cs_n is low for CLK_DIV*(2*W_DATA+1) cycles (260 at defaults). Exactly W_DATA rising edges of spi_clk occur while cs_n is low.
  - First rising edge: CLK_DIV cycles after cs_n falls.
  - mosi is stable for CLK_DIV cycles before and after every rising edge.
- Back-to-back: a new tx_valid may be accepted on the first IDLE cycle, which is the same cycle tx_done is high. cs_n is high for at least 1 cycle between frames.
- Reset mid-frame: all outputs return to reset values immediately. No tx_done. The partial frame is abandoned.
- Bit counter width is clog2(W_DATA). Divider width is clog2(CLK_DIV), minimum 1. With CLK_DIV=1, every phase lasts one cycle.

Test Plan:
- Reset: assert rst for 3 cycles with tx_valid=1 -> tx_ready=1, busy=0, spi_cs_n=1, spi_clk=0, mosi=0, tx_done=0 throughout; no frame starts during reset.
- Single frame, defaults: send tx_data=0xA5A50F0F -> bench slave sampling mosi on spi_clk rise captures 0xA5A50F0F. cs_n is low for 260 cycles with 32 spi_clk pulses. tx_done pulses once, on the cycle cs_n rises.
- Busy rejection: pulse tx_valid with 0x12345678 at cycle 50 of a 0xDEADBEEF frame -> slave receives only 0xDEADBEEF, and no second frame follows.
- Back-to-back: hold tx_valid high with 0x00000001, then 0xFFFFFFFF -> two frames separated by exactly 1 cycle of cs_n=1. Slave captures 0x00000001 then 0xFFFFFFFF, with two tx_done pulses.
- Reset mid-frame: assert rst at cycle 100 of a frame -> cs_n=1, spi_clk=0, mosi=0 in the same cycle. No tx_done. A following 0x0000CAFE frame transfers correctly.
- Parameter corner: W_DATA=8, CLK_DIV=1, send 0x81 -> slave captures 0x81. cs_n is low for 17 cycles, and spi_clk toggles every cycle while bits are shifted.
